// File: rtl/gbf_port_scheduler_pkg.sv
// Shared definitions for the GBF port schedulers: index width, PE-to-port
// mapping helpers and the scheduler FSM state encoding.
package gbf_port_scheduler_pkg;

    localparam int          GBF_IDX_W = 8;
    localparam int unsigned GBF_PORTS = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADDR  = 2'd1,
        READ  = 2'd2,
        GRANT = 2'd3
    } state_t;

    // Input GBF: element (i,k) of an i x COL1 operand.
    function automatic int unsigned in_port(int unsigned i, int unsigned k, int unsigned col1);
        return (i * col1 + k) % GBF_PORTS;
    endfunction

    function automatic int unsigned in_slot(int unsigned i, int unsigned k, int unsigned col1);
        return (i * col1 + k) / GBF_PORTS;
    endfunction

    // Weight GBF: element (k,j) of a k x COL2 operand.
    function automatic int unsigned w_port(int unsigned k, int unsigned j, int unsigned col2);
        return (k * col2 + j) % GBF_PORTS;
    endfunction

    function automatic int unsigned w_slot(int unsigned k, int unsigned j, int unsigned col2);
        return (k * col2 + j) / GBF_PORTS;
    endfunction

endpackage

// File: rtl/gbf_port_scheduler_rr_arbiter.sv
// Combinational N-way round-robin arbiter: search begins one past ptr,
// masked requesters are skipped; one-hot and encoded winner outputs.
module rr_arbiter #(
    parameter int N  = 2,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [N-1:0]  mask,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  onehot,
    output logic [PW-1:0] idx,
    output logic          any
);

    localparam int unsigned NU = N;

    logic [31:0]   c32;
    logic [PW-1:0] cand;

    always_comb begin
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        c32    = '0;
        cand   = '0;
        for (int unsigned i = 0; i < NU; i++) begin
            c32  = (32'(ptr) + 32'd1 + 32'(i)) % NU;
            cand = PW'(c32);
            if (!any && req[cand] && !mask[cand]) begin
                any          = 1'b1;
                onehot[cand] = 1'b1;
                idx          = cand;
            end
        end
    end

endmodule

// File: rtl/gbf_port_scheduler.sv
// Per-port GBF read scheduler: round-robin over the PEs mapped to one GBF
// read port, address formation, 1-cycle-latency read and grant pulse.
module gbf_port_scheduler
    import gbf_port_scheduler_pkg::*;
#(
    parameter int N_REQ  = 2,
    parameter int WIDTH  = 32,
    parameter int HEIGHT = 32,
    parameter int STRIDE = 3,
    parameter int IDX_W  = GBF_IDX_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*IDX_W-1:0]    row_idx,
    input  logic [N_REQ*IDX_W-1:0]    col_idx,
    output logic [$clog2(HEIGHT)-1:0] addr,
    output logic                      rd_en,
    input  logic [WIDTH-1:0]          q,
    output logic [WIDTH-1:0]          data_out,
    output logic [N_REQ-1:0]          grant,
    output logic                      busy,
    output logic                      err_oob
);

    localparam int AW = $clog2(HEIGHT);
    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int FW = 2 * IDX_W + $clog2(STRIDE + 1);

    state_t            state, next_state;
    logic [PW-1:0]     ptr, win;
    logic              oob;
    logic [N_REQ-1:0]  win_onehot, arb_mask, arb_onehot;
    logic [PW-1:0]     arb_idx;
    logic              arb_any, take;
    logic [IDX_W-1:0]  sel_row, sel_col;
    logic [FW-1:0]     full;
    logic              in_range;

    rr_arbiter #(.N(N_REQ), .PW(PW)) u_arb (
        .req    (req),
        .mask   (arb_mask),
        .ptr    (ptr),
        .onehot (arb_onehot),
        .idx    (arb_idx),
        .any    (arb_any)
    );

    always_comb begin
        win_onehot      = '0;
        win_onehot[win] = 1'b1;
        // The PE just granted may still hold req during GRANT.
        arb_mask = (state == GRANT) ? win_onehot : '0;
        take     = arb_any && (state == IDLE || state == GRANT);
        sel_row  = '0;
        sel_col  = '0;
        for (int unsigned r = 0; r < N_REQ; r++) begin
            if (arb_idx == PW'(r)) begin
                sel_row = row_idx[r*IDX_W +: IDX_W];
                sel_col = col_idx[r*IDX_W +: IDX_W];
            end
        end
        full     = FW'(sel_row) * FW'(STRIDE) + FW'(sel_col);
        in_range = (full < FW'(HEIGHT));
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    next_state = take ? ADDR : IDLE;
            ADDR:    next_state = READ;
            READ:    next_state = GRANT;
            GRANT:   next_state = take ? ADDR : IDLE;
            default: next_state = IDLE;
        endcase
    end

    // addr/rd_en/oob are registered on the edge entering ADDR, straight from
    // the winner's indices, so rd_en is high during ADDR and q lands in READ.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= PW'(N_REQ - 1);
            win      <= '0;
            oob      <= 1'b0;
            addr     <= '0;
            rd_en    <= 1'b0;
            data_out <= '0;
            grant    <= '0;
            busy     <= 1'b0;
            err_oob  <= 1'b0;
        end else begin
            state   <= next_state;
            busy    <= (next_state != IDLE);
            rd_en   <= 1'b0;
            grant   <= '0;
            err_oob <= 1'b0;
            if (take) begin
                win <= arb_idx;
                oob <= !in_range;
                if (in_range) begin
                    addr  <= full[AW-1:0];
                    rd_en <= 1'b1;
                end
            end
            if (state == READ) begin
                data_out <= oob ? '0 : q;
                grant    <= win_onehot;
                err_oob  <= oob;
                ptr      <= win;
            end
        end
    end

endmodule
